// File: rtl/serial_add_driver_if.sv
// Word-side handshake and serial-adder pin bundle for serial_add_driver.
// slave = the driver itself, master = whatever surrounds it (control logic + adder cell).
interface serial_add_driver_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ser_clr;
    logic         ser_start;
    logic         ser_a;
    logic         ser_b;
    logic         ser_cin;
    logic         ser_s;
    logic         ser_cout;

    modport slave (
        input  in_valid, op_a, op_b, op_cin, out_ready, ser_s, ser_cout,
        output in_ready, out_valid, sum, cout, ser_clr, ser_start, ser_a, ser_b, ser_cin
    );

    modport master (
        output in_valid, op_a, op_b, op_cin, out_ready, ser_s, ser_cout,
        input  in_ready, out_valid, sum, cout, ser_clr, ser_start, ser_a, ser_b, ser_cin
    );
endinterface

// File: rtl/serial_add_driver.sv
// Serialises a word add onto a bit-serial full adder, LSB first, closing the carry
// loop through the adder's registered COUT and reassembling the returned S stream.
module serial_add_driver #(
    parameter int W = 8
) (
    input  logic                CLK,
    input  logic                rst,
    serial_add_driver_if.slave  bus
);
    localparam int KW = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } req_t;

    state_t       state, state_nxt;
    req_t         req_q;
    logic [KW-1:0] k;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         k_first;
    logic         k_last;

    assign k_first = (k == '0);
    assign k_last  = (k == K_LAST);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state  <= IDLE;
            req_q  <= '0;
            k      <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        req_q.a   <= bus.op_a;
                        req_q.b   <= bus.op_b;
                        req_q.cin <= bus.op_cin;
                        k         <= '0;
                    end
                end
                SEND: begin
                    // S for bit k-1 arrives one cycle after it was driven
                    if (!k_first) sum_q[k - 1'b1] <= bus.ser_s;
                    if (!k_last)  k <= k + 1'b1;
                end
                DRAIN: begin
                    sum_q[W-1] <= bus.ser_s;
                    cout_q     <= bus.ser_cout;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.ser_clr   = 1'b0;
        bus.ser_start = 1'b0;
        bus.ser_a     = 1'b0;
        bus.ser_b     = 1'b0;
        bus.ser_cin   = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.ser_clr  = 1'b1;
                if (bus.in_valid) state_nxt = SEND;
            end
            SEND: begin
                bus.ser_start = 1'b1;
                bus.ser_a     = req_q.a[k];
                bus.ser_b     = req_q.b[k];
                // carry loop: adder's registered COUT feeds straight back after bit 0
                bus.ser_cin   = k_first ? req_q.cin : bus.ser_cout;
                if (k_last) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.ser_clr   = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_driver.sv
// Directed bench for serial_add_driver with a behavioural bit-serial adder attached.
module tb_serial_add_driver;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic s_q = 1'b0;
    logic c_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_driver_if #(.W(W)) bus ();

    serial_add_driver #(.W(W)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural serial adder: registered S/COUT, cleared by ser_clr
    always @(posedge clk) begin
        if (bus.ser_clr) begin
            s_q <= 1'b0;
            c_q <= 1'b0;
        end else if (bus.ser_start) begin
            s_q <= bus.ser_a ^ bus.ser_b ^ bus.ser_cin;
            c_q <= (bus.ser_a & bus.ser_b) | (bus.ser_a & bus.ser_cin) | (bus.ser_b & bus.ser_cin);
        end
    end
    assign bus.ser_s    = s_q;
    assign bus.ser_cout = c_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch one add, then count cycles from the accept edge to out_valid
    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
        int n;
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.op_a     = 8'($urandom);
        bus.op_b     = 8'($urandom);
        bus.op_cin   = 1'($urandom);
        n = 1;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd10);
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    endtask

    logic [7:0] ba [3];
    logic [7:0] bb [3];
    logic       bc [3];
    logic [7:0] rs [3];
    logic       rc [3];
    int         rt [3];
    int         n, acc, got, quiet;
    logic       acc_now;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();

        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        check("rst_ser_clr",   32'(bus.ser_clr),   32'd1);
        check("rst_ser_start", 32'(bus.ser_start), 32'd0);
        check("rst_ser_ab",    32'({bus.ser_a, bus.ser_b, bus.ser_cin}), 32'd0);
        rst = 1'b0;
        tick();

        run_txn("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        tick();
        check("t5a3c_ret_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5a3c_ret_out_valid", 32'(bus.out_valid), 32'd0);

        run_txn("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        tick();
        run_txn("tff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        tick();
        run_txn("t0000c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        tick();

        // Backpressure in DONE; a pending in_valid must wait
        bus.out_ready = 1'b0;
        run_txn("bp", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        bus.in_valid = 1'b1;
        bus.op_a     = 8'h10;
        bus.op_b     = 8'h20;
        bus.op_cin   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_sum",       32'({bus.cout, bus.sum}), 32'h033);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_rel_in_ready",  32'(bus.in_ready),  32'd1);
        check("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_next_latency", 32'(n), 32'd10);
        check("bp_next_sum", 32'({bus.cout, bus.sum}), 32'h030);
        tick();

        // Reset pulse while SEND is on bit 3
        bus.in_valid = 1'b1;
        bus.op_a     = 8'hE7;
        bus.op_b     = 8'h5C;
        bus.op_cin   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_ser_start", 32'(bus.ser_start), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_ser_clr",   32'(bus.ser_clr),   32'd1);
        check("mid_ser_start", 32'(bus.ser_start), 32'd0);
        quiet = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.out_valid) quiet++;
            tick();
        end
        check("mid_no_out_valid", 32'(quiet), 32'd0);
        run_txn("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        tick();

        // Back-to-back with in_valid and out_ready held high
        ba[0] = 8'h80; bb[0] = 8'h80; bc[0] = 1'b0;
        ba[1] = 8'h7F; bb[1] = 8'h01; bc[1] = 1'b1;
        ba[2] = 8'hAA; bb[2] = 8'h55; bc[2] = 1'b1;
        acc = 0;
        got = 0;
        bus.in_valid = 1'b1;
        bus.op_a     = ba[0];
        bus.op_b     = bb[0];
        bus.op_cin   = bc[0];
        for (int c = 0; c < 80 && got < 3; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                rs[got] = bus.sum;
                rc[got] = bus.cout;
                rt[got] = cyc;
                got++;
            end
            acc_now = bus.in_valid && bus.in_ready;
            tick();
            if (acc_now) begin
                acc++;
                if (acc < 3) begin
                    bus.op_a   = ba[acc];
                    bus.op_b   = bb[acc];
                    bus.op_cin = bc[acc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", 32'(got), 32'd3);
        check("b2b_r0", 32'({rc[0], rs[0]}), 32'h100);
        check("b2b_r1", 32'({rc[1], rs[1]}), 32'h081);
        check("b2b_r2", 32'({rc[2], rs[2]}), 32'h100);
        check("b2b_gap01", 32'(rt[1] - rt[0]), 32'd11);
        check("b2b_gap12", 32'(rt[2] - rt[1]), 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_add_driver.md
# serial_add_driver

Word-level front end for the bit-serial full-adder datapath. Accepts two W-bit operands plus carry-in over a valid/ready handshake, serialises them LSB-first onto the serial adder's A/B/CIN pins, and closes the carry loop by feeding the adder's registered COUT back as CIN. It collects the returned S bit stream into a parallel W-bit sum and final carry-out, then presents them on a second valid/ready handshake. It sits between the word-oriented control logic and the serial adder cell.

## Interface
- W, default 8: operand/sum width in bits; must be at least 2.
- CLK  input  1  rising-edge clock shared with the serial adder.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  driver can accept an operand word.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  assembled sum.
- cout  output  1  carry-out of bit W-1.
- ser_clr  output  1  clear/hold for the serial adder's rst pin.
- ser_start  output  1  start/run for the serial adder.
- ser_a, ser_b, ser_cin  output  1 each  serial operand bits to the adder.
- ser_s, ser_cout  input  1 each  adder's registered sum and carry bits; one-cycle latency.

## Operation
- FSM states:
  - IDLE: in_ready=1, ser_clr=1. On in_valid, latch op_a, op_b, op_cin, clear bit index k to 0, and go to SEND.
  - SEND: ser_start=1, ser_clr=0. Drive ser_a=a[k] and ser_b=b[k].
    - ser_cin = op_cin when k=0; otherwise ser_cin = ser_cout, a combinational pass-through of the adder's registered carry.
    - When k>0, capture ser_s into sum[k-1].
    - At k=W-1, go to DRAIN; otherwise increment k.
  - DRAIN: ser_start=0, ser_clr=0. Capture ser_s into sum[W-1] and ser_cout into cout. Go to DONE.
  - DONE: out_valid=1, ser_clr=1. Hold sum and cout stable. On out_ready, go to IDLE.
- in_ready is high only in IDLE and out_valid is high only in DONE, so the driver holds exactly one transaction in flight.
- Operands are latched in full at acceptance. Changes on op_* after the handshake have no effect.
- Arithmetic: {cout,sum} = op_a + op_b + op_cin, computed modulo 2^(W+1).
- rst at any cycle, including mid-SEND or DONE: the FSM goes to IDLE on the next edge, the current transaction is dropped, and no out_valid pulse is produced.
- Reset values: in_ready=1 (IDLE); out_valid=0; sum=0; cout=0; ser_clr=1; ser_start=0; ser_a=0; ser_b=0.
- ser_cin is 0 while not in SEND.
- sum and cout keep their last value in IDLE. They are only meaningful while out_valid=1.

## Timing
- Cycle 0: in_valid&&in_ready sampled at the edge.
- Cycles 1..W: SEND. Bit k is driven in cycle k+1.
- Cycle W+1: DRAIN.
- Cycle W+2: out_valid=1. Accept-to-result latency is W+2 cycles when out_ready is already high.
- The result handshake completes at the first edge where out_valid&&out_ready are both high. in_ready rises the following cycle.
- Throughput: one word per W+3 cycles with no backpressure.
- Serial adder contract: S/COUT for the bits presented in cycle t are valid in cycle t+1. The adder's carry is ignored while ser_clr=1.

## Test plan
Bench uses a behavioural serial adder: registered S=a^b^cin, COUT=maj(a,b,cin), both cleared when ser_clr=1.
- W=8: op_a=0x5A, op_b=0x3C, op_cin=0 → sum=0x96, cout=0; out_valid first high exactly 10 cycles after acceptance.
- W=8: 0xFF+0x01, cin=0 → sum=0x00, cout=1. Covers full carry ripple through the feedback path.
- W=8: 0xFF+0x00, cin=1 → sum=0x00, cout=1; 0x00+0x00, cin=1 → sum=0x01, cout=0. Covers bit-0 CIN handling.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: sum/cout stable, in_ready=0, a new in_valid is not accepted. Release out_ready: in_ready=1 one cycle after the handshake.
- Reset mid-operation: assert rst for one cycle during SEND at k=3. Required: next cycle in IDLE, in_ready=1, ser_clr=1, ser_start=0, no out_valid. A following 0x12+0x34 → 0x46, cout=0.
- Back-to-back: three transactions with in_valid and out_ready held high. Required: results in order, 11 cycles apart.
